// File: rtl/interval_timer_sequencer_pkg.sv
// Shared definitions for the interval-timer sequencer: timer register map,
// control-word bit positions and the bus-sequencing state encoding.
package interval_timer_sequencer_pkg;

   localparam logic [2:0] ADDR_STATUS  = 3'd0;
   localparam logic [2:0] ADDR_CONTROL = 3'd1;
   localparam logic [2:0] ADDR_PERIODL = 3'd2;
   localparam logic [2:0] ADDR_PERIODH = 3'd3;
   localparam logic [2:0] ADDR_SNAPL   = 3'd4;
   localparam logic [2:0] ADDR_SNAPH   = 3'd5;

   localparam int CTRL_ITO_BIT   = 0;
   localparam int CTRL_CONT_BIT  = 1;
   localparam int CTRL_START_BIT = 2;
   localparam int CTRL_STOP_BIT  = 3;

   // One state per bus cycle.
   typedef enum logic [3:0] {
      ST_IDLE,
      ST_WR_PL,
      ST_WR_PH,
      ST_WR_CT,
      ST_RUN,
      ST_CLR_ST,
      ST_IRQ_WT,
      ST_SN_WR,
      ST_SN_RL,
      ST_SN_RH,
      ST_SN_DN,
      ST_STOP_WR
   } state_e;

   // Places a {STOP, START, CONT, ITO} nibble onto the control register bits.
   function automatic logic [15:0] ctrl_data(input logic [3:0] c);
      logic [15:0] w;
      w                 = '0;
      w[CTRL_ITO_BIT]   = c[0];
      w[CTRL_CONT_BIT]  = c[1];
      w[CTRL_START_BIT] = c[2];
      w[CTRL_STOP_BIT]  = c[3];
      return w;
   endfunction

endpackage

// File: rtl/interval_timer_sequencer.sv
// Avalon-MM initiator that programs the interval timer, services its irq into
// a sample_tick stream and fetches counter snapshots, with no CPU involvement.
module interval_timer_sequencer
   import interval_timer_sequencer_pkg::*;
#(
   parameter logic [3:0] CTRL_RUN  = 4'b0111,
   parameter logic [3:0] CTRL_STOP = 4'b1000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        stop,
   input  logic        snap_req,
   input  logic [31:0] period_in,
   output logic [2:0]  av_address,
   output logic        av_chipselect,
   output logic        av_write_n,
   output logic [15:0] av_writedata,
   input  logic [15:0] av_readdata,
   input  logic        timer_irq,
   output logic        busy,
   output logic        running,
   output logic        sample_tick,
   output logic [15:0] tick_count,
   output logic [31:0] snap_value,
   output logic        snap_valid,
   output logic        cfg_err
);

   state_e      state_q, state_d;
   logic [31:0] period_q, period_d;
   logic [15:0] tick_count_q, tick_count_d;
   logic [15:0] snap_lo_q, snap_lo_d;
   logic [31:0] snap_value_q, snap_value_d;
   logic        stop_pend_q, stop_pend_d;
   logic        snap_pend_q, snap_pend_d;
   logic        ret_run_q, ret_run_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         period_q     <= '0;
         tick_count_q <= '0;
         snap_lo_q    <= '0;
         snap_value_q <= '0;
         stop_pend_q  <= 1'b0;
         snap_pend_q  <= 1'b0;
         ret_run_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         period_q     <= period_d;
         tick_count_q <= tick_count_d;
         snap_lo_q    <= snap_lo_d;
         snap_value_q <= snap_value_d;
         stop_pend_q  <= stop_pend_d;
         snap_pend_q  <= snap_pend_d;
         ret_run_q    <= ret_run_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      period_d      = period_q;
      tick_count_d  = tick_count_q;
      snap_lo_d     = snap_lo_q;
      snap_value_d  = snap_value_q;
      stop_pend_d   = stop_pend_q;
      snap_pend_d   = snap_pend_q;
      ret_run_d     = ret_run_q;
      av_address    = ADDR_STATUS;
      av_chipselect = 1'b0;
      av_write_n    = 1'b1;
      av_writedata  = '0;
      sample_tick   = 1'b0;
      snap_valid    = 1'b0;
      cfg_err       = start && (state_q != ST_IDLE);

      // Pulses landing mid-sequence are remembered and serviced back in RUN.
      if (state_q != ST_IDLE && state_q != ST_RUN) begin
         if (stop)     stop_pend_d = 1'b1;
         if (snap_req) snap_pend_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (start && period_in != '0) begin
               period_d    = period_in;
               snap_pend_d = snap_req;
               state_d     = ST_WR_PL;
            end else begin
               cfg_err = start;
               if (snap_req) begin
                  ret_run_d = 1'b0;
                  state_d   = ST_SN_WR;
               end
            end
         end
         ST_WR_PL: begin
            av_chipselect = 1'b1;
            av_write_n    = 1'b0;
            av_address    = ADDR_PERIODL;
            av_writedata  = period_q[15:0];
            state_d       = ST_WR_PH;
         end
         ST_WR_PH: begin
            av_chipselect = 1'b1;
            av_write_n    = 1'b0;
            av_address    = ADDR_PERIODH;
            av_writedata  = period_q[31:16];
            state_d       = ST_WR_CT;
         end
         ST_WR_CT: begin
            av_chipselect = 1'b1;
            av_write_n    = 1'b0;
            av_address    = ADDR_CONTROL;
            av_writedata  = ctrl_data(CTRL_RUN);
            tick_count_d  = '0;
            state_d       = ST_RUN;
         end
         ST_RUN: begin
            if (timer_irq) begin
               stop_pend_d = stop_pend_q | stop;
               snap_pend_d = snap_pend_q | snap_req;
               state_d     = ST_CLR_ST;
            end else if (stop || stop_pend_q) begin
               stop_pend_d = 1'b0;
               snap_pend_d = snap_pend_q | snap_req;
               state_d     = ST_STOP_WR;
            end else if (snap_req || snap_pend_q) begin
               snap_pend_d = 1'b0;
               ret_run_d   = 1'b1;
               state_d     = ST_SN_WR;
            end
         end
         ST_CLR_ST: begin
            av_chipselect = 1'b1;
            av_write_n    = 1'b0;
            av_address    = ADDR_STATUS;
            sample_tick   = 1'b1;
            tick_count_d  = tick_count_q + 16'd1;
            state_d       = ST_IRQ_WT;
         end
         // The timer drops irq one cycle after the status write; skip a cycle
         // so RUN does not see the stale level.
         ST_IRQ_WT: state_d = ST_RUN;
         ST_SN_WR: begin
            av_chipselect = 1'b1;
            av_write_n    = 1'b0;
            av_address    = ADDR_SNAPL;
            state_d       = ST_SN_RL;
         end
         ST_SN_RL: begin
            av_chipselect = 1'b1;
            av_address    = ADDR_SNAPL;
            state_d       = ST_SN_RH;
         end
         ST_SN_RH: begin
            av_chipselect = 1'b1;
            av_address    = ADDR_SNAPH;
            snap_lo_d     = av_readdata;
            state_d       = ST_SN_DN;
         end
         ST_SN_DN: begin
            snap_value_d = {av_readdata, snap_lo_q};
            snap_valid   = 1'b1;
            if (ret_run_q) begin
               state_d = ST_RUN;
            end else begin
               stop_pend_d = 1'b0;
               snap_pend_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         ST_STOP_WR: begin
            av_chipselect = 1'b1;
            av_write_n    = 1'b0;
            av_address    = ADDR_CONTROL;
            av_writedata  = ctrl_data(CTRL_STOP);
            stop_pend_d   = 1'b0;
            snap_pend_d   = 1'b0;
            state_d       = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign busy       = (state_q != ST_IDLE) && (state_q != ST_RUN);
   assign running    = (state_q == ST_RUN) || (state_q == ST_CLR_ST) ||
                       (state_q == ST_IRQ_WT) || (state_q == ST_STOP_WR) ||
                       (ret_run_q && (state_q == ST_SN_WR || state_q == ST_SN_RL ||
                                      state_q == ST_SN_RH || state_q == ST_SN_DN));
   assign tick_count = tick_count_q;
   // Presented combinationally so the new value lines up with snap_valid.
   assign snap_value = snap_value_d;

endmodule

// File: tb/tb_interval_timer_sequencer.sv
// Bench for interval_timer_sequencer: a behavioural interval-timer slave plus
// a bus-write scoreboard, a table of start vectors and hand-written corner sequences.
module tb_interval_timer_sequencer;

   logic        clk = 1'b0;
   logic        reset, start, stop, snap_req;
   logic [31:0] period_in;
   logic [2:0]  av_address;
   logic        av_chipselect, av_write_n;
   logic [15:0] av_writedata, av_readdata;
   logic        timer_irq, busy, running, sample_tick, snap_valid, cfg_err;
   logic [15:0] tick_count;
   logic [31:0] snap_value;

   always #5 clk = ~clk;

   interval_timer_sequencer dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .snap_req(snap_req),
      .period_in(period_in), .av_address(av_address), .av_chipselect(av_chipselect),
      .av_write_n(av_write_n), .av_writedata(av_writedata), .av_readdata(av_readdata),
      .timer_irq(timer_irq), .busy(busy), .running(running), .sample_tick(sample_tick),
      .tick_count(tick_count), .snap_value(snap_value), .snap_valid(snap_valid),
      .cfg_err(cfg_err)
   );

   // Interval-timer slave: counts period..0, flags TO at 0 and reloads.
   logic [15:0] t_pl = '0, t_ph = '0, t_rd = '0;
   logic [31:0] t_cnt = '0, t_snap = '0;
   logic        t_to = 1'b0, t_run = 1'b0, t_ito = 1'b0, t_cont = 1'b0;

   always @(posedge clk) begin
      if (t_run) begin
         if (t_cnt == 0) begin
            t_to  <= 1'b1;
            t_cnt <= {t_ph, t_pl};
            if (!t_cont) t_run <= 1'b0;
         end else begin
            t_cnt <= t_cnt - 1;
         end
      end
      if (av_chipselect && !av_write_n) begin
         case (av_address)
            3'd0: t_to <= 1'b0;
            3'd1: begin
               t_ito  <= av_writedata[0];
               t_cont <= av_writedata[1];
               if (av_writedata[2]) t_run <= 1'b1;
               if (av_writedata[3]) t_run <= 1'b0;
            end
            3'd2: begin t_pl <= av_writedata; t_cnt <= {t_ph, av_writedata}; end
            3'd3: begin t_ph <= av_writedata; t_cnt <= {av_writedata, t_pl}; end
            3'd4, 3'd5: t_snap <= t_cnt;
            default: ;
         endcase
      end
      if (av_chipselect && av_write_n) begin
         case (av_address)
            3'd0: t_rd <= {14'd0, t_run, t_to};
            3'd1: t_rd <= {12'd0, 1'b0, 1'b0, t_cont, t_ito};
            3'd2: t_rd <= t_pl;
            3'd3: t_rd <= t_ph;
            3'd4: t_rd <= t_snap[15:0];
            3'd5: t_rd <= t_snap[31:16];
            default: t_rd <= '0;
         endcase
      end else begin
         t_rd <= '0;
      end
   end

   assign timer_irq   = t_to && t_ito;
   assign av_readdata = t_rd;

   // Scoreboard: {data_checked, addr, data} per expected bus write.
   logic [19:0] exp_q[$];
   logic [19:0] e;
   int          checks = 0;
   int          errors = 0;
   int          cs_count = 0;
   logic        irq_prev = 1'b0;
   longint      last_tick_t = -1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_wr(input logic care, input logic [2:0] a, input logic [15:0] d);
      exp_q.push_back({care, a, d});
   endtask

   always @(negedge clk) begin
      // Every new irq level must be answered by exactly one status clear.
      if (timer_irq && !irq_prev) push_wr(1'b1, 3'd0, 16'h0000);
      irq_prev = timer_irq;
      if (av_chipselect) cs_count++;
      if (av_chipselect && !av_write_n) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL bus_write unexpected: addr=%0d data=0x%h at %0t", av_address, av_writedata, $time);
         end else begin
            e = exp_q.pop_front();
            if (av_address !== e[18:16] || (e[19] && av_writedata !== e[15:0])) begin
               errors++;
               $display("FAIL bus_write: got addr=%0d data=0x%h expected addr=%0d data=0x%h at %0t",
                        av_address, av_writedata, e[18:16], e[15:0], $time);
            end
         end
      end
   end

   task automatic pulse_start(input logic [31:0] p, input logic exp_err);
      int cs0;
      @(negedge clk);
      #1;
      start     = 1'b1;
      period_in = p;
      cs0       = cs_count;
      #1 chk("start_cfg_err", {31'd0, cfg_err}, {31'd0, exp_err});
      if (!exp_err) begin
         push_wr(1'b1, 3'd2, p[15:0]);
         push_wr(1'b1, 3'd3, p[31:16]);
         push_wr(1'b1, 3'd1, 16'h0007);
      end
      @(negedge clk);
      #1 start = 1'b0;
      if (!exp_err) begin
         chk("start_wr_pl_cycle", {28'd0, av_chipselect, av_write_n, av_address}, {28'd0, 1'b1, 1'b0, 3'd2});
         @(negedge clk);
         chk("start_wr_ph_cycle", {28'd0, av_chipselect, av_write_n, av_address}, {28'd0, 1'b1, 1'b0, 3'd3});
         @(negedge clk);
         chk("start_wr_ct_cycle", {28'd0, av_chipselect, av_write_n, av_address}, {28'd0, 1'b1, 1'b0, 3'd1});
         @(negedge clk);
         chk("start_running", {30'd0, running, busy}, {30'd0, 1'b1, 1'b0});
         chk("start_tick_count_clear", {16'd0, tick_count}, 32'd0);
      end else begin
         repeat (3) @(negedge clk);
         chk("rejected_start_no_bus", cs_count - cs0, 32'd0);
         chk("rejected_start_not_busy", {31'd0, busy}, 32'd0);
      end
   endtask

   task automatic do_stop();
      @(negedge clk);
      #1 stop = 1'b1;
      push_wr(1'b1, 3'd1, 16'h0008);
      @(negedge clk);
      #1 stop = 1'b0;
      chk("stop_wr_cycle", {28'd0, av_chipselect, av_write_n, av_address}, {28'd0, 1'b1, 1'b0, 3'd1});
      @(negedge clk);
      chk("stop_idle", {30'd0, running, busy}, 32'd0);
   endtask

   task automatic wait_tick(input logic spacing, output logic got);
      got = 1'b0;
      for (int i = 0; i < 60 && !got; i++) begin
         @(negedge clk);
         if (sample_tick) got = 1'b1;
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL tick_timeout: got no sample_tick expected one within 60 cycles at %0t", $time);
      end else begin
         if (spacing && last_tick_t >= 0) chk("tick_spacing", 32'(($time - last_tick_t) / 10), 32'd17);
         last_tick_t = $time;
      end
   endtask

   typedef struct packed {
      logic [31:0] period;
      logic        from_run;
      logic        exp_err;
   } vec_t;

   vec_t vecs [6];

   initial begin
      logic        got;
      logic        found;
      logic [31:0] frozen;

      vecs[0] = '{period: 32'h0000_0010, from_run: 1'b0, exp_err: 1'b0};
      vecs[1] = '{period: 32'h0000_0000, from_run: 1'b0, exp_err: 1'b1};
      vecs[2] = '{period: 32'hFFFF_0003, from_run: 1'b0, exp_err: 1'b0};
      vecs[3] = '{period: 32'h0000_0020, from_run: 1'b1, exp_err: 1'b1};
      vecs[4] = '{period: 32'h1234_5678, from_run: 1'b0, exp_err: 1'b0};
      vecs[5] = '{period: 32'h0000_0000, from_run: 1'b1, exp_err: 1'b1};

      reset = 1'b0; start = 1'b0; stop = 1'b0; snap_req = 1'b0; period_in = '0;
      #2 reset = 1'b1;
      @(negedge clk);
      chk("reset_bus", {10'd0, av_chipselect, av_write_n, av_address, av_writedata},
          {10'd0, 1'b0, 1'b1, 3'd0, 16'd0});
      chk("reset_status", {27'd0, busy, running, sample_tick, snap_valid, cfg_err}, 32'd0);
      chk("reset_tick_count", {16'd0, tick_count}, 32'd0);
      chk("reset_snap_value", snap_value, 32'd0);
      #1 reset = 1'b0;

      for (int v = 0; v < 6; v++) begin
         if (vecs[v].from_run) pulse_start(32'h0000_0040, 1'b0);
         pulse_start(vecs[v].period, vecs[v].exp_err);
         if (vecs[v].from_run || !vecs[v].exp_err) do_stop();
      end

      // Continuous run at period 16: one tick every 17 cycles.
      pulse_start(32'h0000_0010, 1'b0);
      last_tick_t = -1;
      for (int k = 1; k <= 5; k++) begin
         wait_tick(1'b1, got);
         @(negedge clk);
         chk("tick_count_step", {16'd0, tick_count}, 32'(k));
         chk("tick_pulse_width", {31'd0, sample_tick}, 32'd0);
         chk("irq_cleared", {31'd0, timer_irq}, 32'd0);
      end

      // Snapshot in RUN, issued while the timer shows 9 so it captures 8.
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (t_cnt == 32'd9 && running && !busy) found = 1'b1;
      end
      chk("snap_count_reached", {31'd0, found}, 32'd1);
      #1 snap_req = 1'b1;
      push_wr(1'b0, 3'd4, 16'h0000);
      @(negedge clk);
      #1 snap_req = 1'b0;
      @(negedge clk);
      chk("snap_read_lo", {28'd0, av_chipselect, av_write_n, av_address}, {28'd0, 1'b1, 1'b1, 3'd4});
      @(negedge clk);
      chk("snap_read_hi", {28'd0, av_chipselect, av_write_n, av_address}, {28'd0, 1'b1, 1'b1, 3'd5});
      @(negedge clk);
      chk("snap_valid_latency", {31'd0, snap_valid}, 32'd1);
      chk("snap_value_run", snap_value, 32'd8);
      @(negedge clk);
      chk("snap_valid_width", {31'd0, snap_valid}, 32'd0);
      chk("snap_value_held", snap_value, 32'd8);

      // Wrap of tick_count: jump close to the top, then let ticks carry it over.
      force dut.tick_count_q = 16'hFFFE;
      @(negedge clk);
      release dut.tick_count_q;
      wait_tick(1'b1, got);
      @(negedge clk);
      chk("tick_count_ffff", {16'd0, tick_count}, 32'h0000_FFFF);
      chk("tick_ffff_width", {31'd0, sample_tick}, 32'd0);
      wait_tick(1'b1, got);
      @(negedge clk);
      chk("tick_count_wrap", {16'd0, tick_count}, 32'd0);
      chk("tick_wrap_width", {31'd0, sample_tick}, 32'd0);

      // irq and stop in the same cycle: service first, then stop.
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (timer_irq && running && !busy) found = 1'b1;
      end
      chk("irq_stop_irq_seen", {31'd0, found}, 32'd1);
      #1 stop = 1'b1;
      push_wr(1'b1, 3'd1, 16'h0008);
      @(negedge clk);
      #1 stop = 1'b0;
      chk("irq_stop_tick", {31'd0, sample_tick}, 32'd1);
      repeat (3) @(negedge clk);
      chk("irq_stop_ctrl_cycle", {28'd0, av_chipselect, av_write_n, av_address}, {28'd0, 1'b1, 1'b0, 3'd1});
      @(negedge clk);
      chk("irq_stop_idle", {30'd0, running, busy}, 32'd0);
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (timer_irq || sample_tick) found = 1'b1;
      end
      chk("stopped_no_irq", {31'd0, found}, 32'd0);

      // Snapshot from IDLE returns to IDLE with the frozen count.
      @(negedge clk);
      frozen = t_cnt;
      #1 snap_req = 1'b1;
      push_wr(1'b0, 3'd4, 16'h0000);
      @(negedge clk);
      #1 snap_req = 1'b0;
      chk("idle_snap_busy", {30'd0, running, busy}, {30'd0, 1'b0, 1'b1});
      repeat (3) @(negedge clk);
      chk("idle_snap_valid", {31'd0, snap_valid}, 32'd1);
      chk("idle_snap_value", snap_value, frozen);
      @(negedge clk);
      chk("idle_snap_back_idle", {30'd0, running, busy}, 32'd0);

      // Reset while the high period half is on the bus.
      @(negedge clk);
      #1 start = 1'b1;
      period_in = 32'h0000_0010;
      push_wr(1'b1, 3'd2, 16'h0010);
      push_wr(1'b1, 3'd3, 16'h0000);
      @(negedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      chk("reset_mid_in_wr_ph", {29'd0, av_address}, 32'd3);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("reset_mid_bus", {10'd0, av_chipselect, av_write_n, av_address, av_writedata},
          {10'd0, 1'b0, 1'b1, 3'd0, 16'd0});
      chk("reset_mid_status", {30'd0, running, busy}, 32'd0);
      #1 reset = 1'b0;
      pulse_start(32'h0000_0010, 1'b0);
      do_stop();

      repeat (2) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test expected finish before time 200000");
      $fatal(1, "watchdog expired");
   end

endmodule
